// File: rtl/inertial_interface.sv
// SPI master (mode 3, 16-bit frames) and sequencer for the 6-axis inertial sensor.
// Initializes the sensor, then reads pitch rate and Z acceleration on each data-ready.
module inertial_interface #(
   parameter int INIT_WAIT  = 65536,
   parameter int SCLK_DIV_W = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        INT,
   input  logic        MISO,
   output logic        SS_n,
   output logic        SCLK,
   output logic        MOSI,
   output logic        vld,
   output logic [15:0] ptch_rt,
   output logic [15:0] AZ
);

   localparam int WAIT_W = (INIT_WAIT > 1) ? $clog2(INIT_WAIT) : 1;
   localparam logic [SCLK_DIV_W-1:0] DIV_ONES = {SCLK_DIV_W{1'b1}};
   localparam logic [SCLK_DIV_W-1:0] DIV_LOAD = {1'b1, 1'b0, {(SCLK_DIV_W-2){1'b1}}};
   localparam logic [SCLK_DIV_W-1:0] DIV_RISE = {1'b0, {(SCLK_DIV_W-1){1'b1}}};

   typedef enum logic [3:0] {
      WAIT_PWR, INIT1, INIT2, INIT3, INIT4, IDLE, RD_PL, RD_PH, RD_AL, RD_AH
   } state_t;

   state_t                  state_reg, state_next;
   logic [WAIT_W-1:0]       pwr_cnt_reg, pwr_cnt_next;
   logic                    int_meta_reg, int_sync_reg;
   logic                    ss_n_reg, done_reg, sent_reg;
   logic [SCLK_DIV_W-1:0]   div_reg;
   logic [4:0]              rise_cnt_reg;
   logic [15:0]             tx_reg;
   logic [7:0]              rx_reg;
   logic [7:0]              pl_reg, ph_reg, al_reg;
   logic [15:0]             ptch_reg, az_reg;
   logic                    vld_reg;
   logic                    xfer, spi_start;
   logic [15:0]             cmd;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         int_meta_reg <= 1'b0;
         int_sync_reg <= 1'b0;
      end else begin
         int_meta_reg <= INT;
         int_sync_reg <= int_meta_reg;
      end
   end

   // SPI engine: divider MSB is SCLK; rise at DIV_RISE->next, fall at all-ones->0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ss_n_reg     <= 1'b1;
         done_reg     <= 1'b0;
         div_reg      <= DIV_ONES;
         rise_cnt_reg <= 5'd0;
         tx_reg       <= 16'h0000;
         rx_reg       <= 8'h00;
      end else begin
         done_reg <= 1'b0;
         if (ss_n_reg) begin
            div_reg <= DIV_ONES;
            if (spi_start) begin
               ss_n_reg     <= 1'b0;
               div_reg      <= DIV_LOAD;
               tx_reg       <= cmd;
               rise_cnt_reg <= 5'd0;
            end
         end else if (div_reg == DIV_ONES && rise_cnt_reg == 5'd16) begin
            ss_n_reg <= 1'b1;
            done_reg <= 1'b1;
         end else begin
            div_reg <= div_reg + {{(SCLK_DIV_W-1){1'b0}}, 1'b1};
            if (div_reg == DIV_RISE) begin
               rx_reg       <= {rx_reg[6:0], MISO};
               rise_cnt_reg <= rise_cnt_reg + 5'd1;
            end
            // Bit 15 is already on MOSI at SS_n fall, so the first fall does not shift.
            if (div_reg == DIV_ONES && rise_cnt_reg != 5'd0)
               tx_reg <= {tx_reg[14:0], 1'b0};
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= WAIT_PWR;
         pwr_cnt_reg <= '0;
         sent_reg    <= 1'b0;
      end else begin
         state_reg   <= state_next;
         pwr_cnt_reg <= pwr_cnt_next;
         if (done_reg)
            sent_reg <= 1'b0;
         else if (spi_start)
            sent_reg <= 1'b1;
      end
   end

   always_comb begin
      state_next   = state_reg;
      pwr_cnt_next = pwr_cnt_reg;
      cmd          = 16'h0000;
      xfer         = 1'b0;
      case (state_reg)
         WAIT_PWR: begin
            if (pwr_cnt_reg == WAIT_W'(INIT_WAIT - 1))
               state_next = INIT1;
            else
               pwr_cnt_next = pwr_cnt_reg + WAIT_W'(1);
         end
         INIT1: begin xfer = 1'b1; cmd = 16'h0D02; if (done_reg) state_next = INIT2; end
         INIT2: begin xfer = 1'b1; cmd = 16'h1053; if (done_reg) state_next = INIT3; end
         INIT3: begin xfer = 1'b1; cmd = 16'h1150; if (done_reg) state_next = INIT4; end
         INIT4: begin xfer = 1'b1; cmd = 16'h1460; if (done_reg) state_next = IDLE;  end
         IDLE:  if (int_sync_reg) state_next = RD_PL;
         RD_PL: begin xfer = 1'b1; cmd = 16'hA200; if (done_reg) state_next = RD_PH; end
         RD_PH: begin xfer = 1'b1; cmd = 16'hA300; if (done_reg) state_next = RD_AL; end
         RD_AL: begin xfer = 1'b1; cmd = 16'hAC00; if (done_reg) state_next = RD_AH; end
         RD_AH: begin xfer = 1'b1; cmd = 16'hAD00; if (done_reg) state_next = IDLE;  end
         default: state_next = WAIT_PWR;
      endcase
   end

   assign spi_start = xfer & ~sent_reg & ss_n_reg;

   // Low bytes are staged so both words become visible together with vld.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pl_reg   <= 8'h00;
         ph_reg   <= 8'h00;
         al_reg   <= 8'h00;
         ptch_reg <= 16'h0000;
         az_reg   <= 16'h0000;
         vld_reg  <= 1'b0;
      end else begin
         vld_reg <= 1'b0;
         if (done_reg) begin
            case (state_reg)
               RD_PL: pl_reg <= rx_reg;
               RD_PH: ph_reg <= rx_reg;
               RD_AL: al_reg <= rx_reg;
               RD_AH: begin
                  ptch_reg <= {ph_reg, pl_reg};
                  az_reg   <= {rx_reg, al_reg};
                  vld_reg  <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   assign SS_n    = ss_n_reg;
   assign SCLK    = ss_n_reg | div_reg[SCLK_DIV_W-1];
   assign MOSI    = ~ss_n_reg & tx_reg[15];
   assign vld     = vld_reg;
   assign ptch_rt = ptch_reg;
   assign AZ      = az_reg;

endmodule

// File: tb/tb_inertial_interface.sv
// Directed bench for inertial_interface with a register-file SPI sensor model.
module tb_inertial_interface;

   localparam int INIT_WAIT = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        INT = 1'b0;
   logic        MISO = 1'b0;
   logic        SS_n, SCLK, MOSI, vld;
   logic [15:0] ptch_rt, AZ;

   always #5 clk = ~clk;

   inertial_interface #(.INIT_WAIT(INIT_WAIT), .SCLK_DIV_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .INT(INT), .MISO(MISO),
      .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI),
      .vld(vld), .ptch_rt(ptch_rt), .AZ(AZ)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Sensor model: logs MOSI words, answers reads from mem[addr] in the data byte.
   logic [7:0]  mem [0:127];
   logic [15:0] mosi_word;
   logic [6:0]  addr;
   logic [7:0]  rd_byte;
   logic        armed = 1'b0;
   int          rises = 0;
   int          low_cnt = 0;
   logic [15:0] log_w [0:63];
   int          log_bits [0:63];
   int          log_len [0:63];
   int          log_n = 0;
   int          cyc = 0;

   always @(posedge clk) begin
      cyc++;
      if (!SS_n) low_cnt++;
   end

   always @(negedge SS_n) begin
      armed = 1'b1;
      rises = 0;
      low_cnt = 0;
      mosi_word = 16'h0000;
      MISO = 1'b0;
   end

   always @(posedge SCLK) begin
      if (!SS_n && armed) begin
         mosi_word = {mosi_word[14:0], MOSI};
         rises++;
         if (rises == 8) addr = mosi_word[6:0];
      end
   end

   always @(negedge SCLK) begin
      if (!SS_n && armed) begin
         if (rises >= 8 && rises < 16) begin
            rd_byte = mem[addr];
            MISO = rd_byte[15 - rises];
         end else begin
            MISO = 1'b0;
         end
      end
   end

   always @(posedge SS_n) begin
      if (armed) begin
         armed = 1'b0;
         if (log_n < 64) begin
            log_w[log_n] = mosi_word;
            log_bits[log_n] = rises;
            log_len[log_n] = low_cnt;
         end
         $display("spi txn %0d: mosi=%04h bits=%0d len=%0d", log_n, mosi_word, rises, low_cnt);
         log_n++;
      end
   end

   // Output monitor, sampled on the falling clock edge.
   int          vld_count = 0;
   int          dbl_vld = 0;
   int          chg = 0;
   int          last_vld_cyc = 0;
   int          prev_vld_cyc = 0;
   logic        prev_vld = 1'b0;
   logic        prev_rst = 1'b0;
   logic [15:0] prev_p = 16'h0, prev_a = 16'h0;
   logic [15:0] vld_p = 16'h0, vld_a = 16'h0;

   always @(negedge clk) begin
      if (rst_n && prev_rst) begin
         if (vld) begin
            vld_count++;
            if (prev_vld) dbl_vld++;
            prev_vld_cyc = last_vld_cyc;
            last_vld_cyc = cyc;
            vld_p = ptch_rt;
            vld_a = AZ;
         end else if (ptch_rt !== prev_p || AZ !== prev_a) begin
            chg++;
         end
      end
      prev_vld = vld;
      prev_p = ptch_rt;
      prev_a = AZ;
      prev_rst = rst_n;
   end

   task automatic wait_log(input int n, input int budget, input string tag);
      int k = 0;
      while (log_n < n && k < budget) begin
         @(negedge clk);
         k++;
      end
      check(tag, log_n, n);
   endtask

   task automatic wait_vld(input int n, input int budget, input string tag);
      int k = 0;
      while (vld_count < n && k < budget) begin
         @(negedge clk);
         k++;
      end
      check(tag, vld_count, n);
   endtask

   task automatic set_data(input logic [7:0] pl, input logic [7:0] ph,
                           input logic [7:0] al, input logic [7:0] ah);
      mem[7'h22] = pl;
      mem[7'h23] = ph;
      mem[7'h2C] = al;
      mem[7'h2D] = ah;
   endtask

   logic [15:0] exp_init [0:3];
   logic [15:0] exp_rd   [0:3];

   initial begin
      int base;
      int bad;
      int ah_cnt;
      int sp;
      int vld_before;

      exp_init[0] = 16'h0D02; exp_init[1] = 16'h1053;
      exp_init[2] = 16'h1150; exp_init[3] = 16'h1460;
      exp_rd[0] = 16'hA200; exp_rd[1] = 16'hA300;
      exp_rd[2] = 16'hAC00; exp_rd[3] = 16'hAD00;
      for (int i = 0; i < 128; i++) mem[i] = 8'h00;

      #2 rst_n = 1'b0;
      #20;
      check("rst_ss_n", SS_n, 1);
      check("rst_sclk", SCLK, 1);
      check("rst_mosi", MOSI, 0);
      check("rst_vld", vld, 0);
      check("rst_ptch", ptch_rt, 16'h0000);
      check("rst_az", AZ, 16'h0000);
      @(negedge clk) rst_n = 1'b1;

      // INT pulse during INIT2 must not trigger reads
      wait_log(1, 600, "wait_init1");
      repeat (20) @(negedge clk);
      INT = 1'b1;
      repeat (30) @(negedge clk);
      INT = 1'b0;
      wait_log(4, 1200, "wait_init4");
      for (int i = 0; i < 4; i++) begin
         check($sformatf("init_cmd%0d", i), log_w[i], exp_init[i]);
         check($sformatf("init_len%0d", i), log_len[i], 261);
         check($sformatf("init_bits%0d", i), log_bits[i], 16);
      end
      repeat (400) @(negedge clk);
      check("no_rd_after_init_int", log_n, 4);
      check("no_vld_in_init", vld_count, 0);
      check("sclk_idle_high", SCLK, 1);

      // single read set
      set_data(8'h34, 8'h12, 8'h78, 8'hFE);
      INT = 1'b1;
      repeat (10) @(negedge clk);
      INT = 1'b0;
      wait_vld(1, 1500, "wait_vld1");
      for (int i = 0; i < 4; i++)
         check($sformatf("rd1_cmd%0d", i), log_w[4 + i], exp_rd[i]);
      check("rd1_ptch", vld_p, 16'h1234);
      check("rd1_az", vld_a, 16'hFE78);

      // negative data, INT pulsed during RD_AL
      set_data(8'h00, 8'h80, 8'hFF, 8'hFF);
      INT = 1'b1;
      repeat (10) @(negedge clk);
      INT = 1'b0;
      wait_log(10, 1200, "wait_rd_al");
      repeat (20) @(negedge clk);
      check("in_rd_al", SS_n, 0);
      INT = 1'b1;
      repeat (30) @(negedge clk);
      INT = 1'b0;
      wait_vld(2, 1200, "wait_vld2");
      repeat (600) @(negedge clk);
      check("rd_al_int_ignored", log_n, 12);
      check("vld_count2", vld_count, 2);
      for (int i = 0; i < 4; i++)
         check($sformatf("rd2_cmd%0d", i), log_w[8 + i], exp_rd[i]);
      check("neg_ptch", vld_p, 16'h8000);
      check("neg_az", vld_a, 16'hFFFF);

      // INT held high: back-to-back read sets
      set_data(8'h34, 8'h12, 8'h78, 8'hFE);
      INT = 1'b1;
      wait_vld(4, 3000, "wait_vld4");
      INT = 1'b0;
      sp = last_vld_cyc - prev_vld_cyc;
      check("vld_spacing_ok", (sp >= 1048 && sp <= 1064), 1);
      check("cont_ptch", vld_p, 16'h1234);
      check("cont_az", vld_a, 16'hFE78);
      repeat (1300) @(negedge clk);
      ah_cnt = 0;
      bad = 0;
      for (int i = 0; i < log_n && i < 64; i++) begin
         if (log_w[i] == 16'hAD00 && log_bits[i] == 16) ah_cnt++;
         if (log_len[i] != 261 || log_bits[i] != 16) bad++;
      end
      check("vld_eq_sets", vld_count, ah_cnt);
      check("txn_shape_all", bad, 0);
      check("no_double_vld", dbl_vld, 0);
      check("hold_between_vld", chg, 0);

      // reset in the middle of RD_PH
      vld_before = vld_count;
      base = log_n;
      INT = 1'b1;
      wait_log(base + 1, 600, "wait_rd_pl");
      repeat (10) @(negedge clk);
      INT = 1'b0;
      repeat (50) @(negedge clk);
      check("in_rd_ph", SS_n, 0);
      #3 rst_n = 1'b0;
      #1;
      check("arst_ss_n", SS_n, 1);
      check("arst_sclk", SCLK, 1);
      check("arst_vld", vld, 0);
      check("arst_ptch", ptch_rt, 16'h0000);
      check("arst_az", AZ, 16'h0000);
      check("aborted_short", (log_bits[base + 1] < 16), 1);
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      wait_log(base + 6, 1600, "wait_reinit");
      for (int i = 0; i < 4; i++)
         check($sformatf("reinit_cmd%0d", i), log_w[base + 2 + i], exp_init[i]);
      repeat (100) @(negedge clk);
      check("no_vld_after_reinit", vld_count, vld_before);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
